cursor_overlay: RTL and testbench
=================================

CURSOR_OVERLAY -- requirements
Module: cursor_overlay

Interface
REQ-001 SHALL have parameter ROW_BITS, default 5, width of row/cursor_y buses.
REQ-002 SHALL have parameter COL_BITS, default 7, width of col/cursor_x buses.
REQ-003 SHALL have parameter ROWS, default 24, number of text rows.
REQ-004 SHALL have parameter COLUMNS, default 80, number of text columns.
REQ-005 SHALL have parameter BLINK_FRAMES, default 32, frames per blink half-period (range 1..255).
REQ-006 SHALL have parameter UL_LINE, default 15, character scanline drawn in underline mode.
REQ-007 SHALL have parameter VIDEO_ON, default 1'b1, active video level.
REQ-008 SHALL have port clk  input  1  single clock; all state is on its rising edge.
REQ-009 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port hblank  input  1  horizontal blanking.
REQ-011 SHALL have port vblank  input  1  vertical blanking.
REQ-012 SHALL have port row  input  ROW_BITS  text row of the current pixel.
REQ-013 SHALL have port col  input  COL_BITS  text column of the current pixel.
REQ-014 SHALL have port scanline  input  4  scanline of the current pixel within its character cell.
REQ-015 SHALL have port char_pixel  input  1  glyph pixel from the character generator.
REQ-016 SHALL have port new_cursor_x  input  COL_BITS  requested cursor column.
REQ-017 SHALL have port new_cursor_y  input  ROW_BITS  requested cursor row.
REQ-018 SHALL have port new_cursor_wen  input  1  one-cycle cursor position write strobe.
REQ-019 SHALL have port cursor_mode  input  2  00 off, 01 steady block, 10 blinking block, 11 blinking underline.
REQ-020 SHALL have port cursor_x  output  COL_BITS  current cursor column.
REQ-021 SHALL have port cursor_y  output  ROW_BITS  current cursor row.
REQ-022 SHALL have port blink_on  output  1  blink phase; 1 = cursor visible.
REQ-023 SHALL have port video  output  1  composited pixel, registered.

Function
REQ-024 Position: on new_cursor_wen, SHALL load cursor_x = min(new_cursor_x, COLUMNS-1) and cursor_y = min(new_cursor_y, ROWS-1), visible the next cycle.
REQ-025 Frame detect: SHALL register vblank and detect its rising edge (vblank=1, previous=0) as one frame tick.
REQ-026 Blink counter: 8-bit; each frame tick SHALL increment it; when the incremented value reaches BLINK_FRAMES, SHALL reset it to 0 and toggle blink_on.
REQ-027 On new_cursor_wen, SHALL clear the blink counter and set blink_on=1; this takes priority over a same-cycle frame tick.
REQ-028 On any change of cursor_mode (registered compare), SHALL clear the blink counter and set blink_on=1.
REQ-029 Cursor hit: hit = (col==cursor_x) & (row==cursor_y).
REQ-030 Cursor pixel: mode 00 -> 0; 01 -> hit; 10 -> hit & blink_on; 11 -> hit & blink_on & (scanline==UL_LINE).
REQ-031 Video: SHALL register video = VIDEO_ON ^ ~(char_pixel ^ cursor_pixel) when hblank=vblank=0, else ~VIDEO_ON; latency is exactly 1 clk from inputs.
REQ-032 Blanking SHALL NOT alter position, counter or blink_on other than through REQ-025..028.
REQ-033 Counter SHALL NOT wrap past BLINK_FRAMES; with BLINK_FRAMES=1, blink_on SHALL toggle on every frame tick.

Reset
REQ-034 While clr=0: cursor_x=0, cursor_y=0, blink counter=0, blink_on=1, registered vblank=1 (no spurious tick at release), stored mode=00, video=~VIDEO_ON.
REQ-035 Reset asserted mid-operation SHALL take effect immediately (asynchronously); the first tick after release needs a real 0->1 vblank transition.

Verification
V1 Write x=100,y=30 (COLUMNS=80,ROWS=24) -> cursor_x=79, cursor_y=23 next cycle.
V2 Mode 10, BLINK_FRAMES=2, 4 vblank pulses -> blink_on 1,1,0,0,1 after pulses 0..4.
V3 wen coincident with vblank rising edge while blink_on=0 -> blink_on=1, counter=0.
V4 Mode 11, cursor (3,2), char_pixel=0, hit at scanline 15 and 14 -> video=1 then 0, each 1 clk after input.
V5 hblank=1 at hit pixel with mode 01 -> video=0; mode 00 with char_pixel=1, no blank -> video=1.
V6 clr pulsed low mid-frame with vblank=1 held -> all outputs at REQ-034 values, no blink tick until vblank falls and rises again.

Source files
------------

// File: rtl/cursor_overlay.sv
// Text-mode cursor overlay: holds the cursor position, runs the frame-based
// blink timer and composites the cursor onto the glyph pixel stream.
module cursor_overlay #(
  parameter int   ROW_BITS     = 5,
  parameter int   COL_BITS     = 7,
  parameter int   ROWS         = 24,
  parameter int   COLUMNS      = 80,
  parameter int   BLINK_FRAMES = 32,
  parameter int   UL_LINE      = 15,
  parameter logic VIDEO_ON     = 1'b1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                hblank,
  input  logic                vblank,
  input  logic [ROW_BITS-1:0] row,
  input  logic [COL_BITS-1:0] col,
  input  logic [3:0]          scanline,
  input  logic                char_pixel,
  input  logic [COL_BITS-1:0] new_cursor_x,
  input  logic [ROW_BITS-1:0] new_cursor_y,
  input  logic                new_cursor_wen,
  input  logic [1:0]          cursor_mode,
  output logic [COL_BITS-1:0] cursor_x,
  output logic [ROW_BITS-1:0] cursor_y,
  output logic                blink_on,
  output logic                video
);

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_STEADY    = 2'b01,
    MODE_BLINK     = 2'b10,
    MODE_UNDERLINE = 2'b11
  } mode_e;

  localparam logic [COL_BITS-1:0] MAX_X      = COL_BITS'(COLUMNS - 1);
  localparam logic [ROW_BITS-1:0] MAX_Y      = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]          BLINK_LAST = 8'(BLINK_FRAMES);
  localparam logic [3:0]          UL_ROW     = 4'(UL_LINE);

  logic       vblank_q;
  logic [1:0] mode_q;
  logic [7:0] blink_cnt;
  logic [7:0] blink_inc;
  logic       frame_tick;
  logic       mode_changed;
  logic       hit;
  logic       cursor_pixel;
  logic       video_d;

  assign frame_tick   = vblank & ~vblank_q;
  assign mode_changed = (cursor_mode != mode_q);
  assign blink_inc    = blink_cnt + 8'd1;
  assign hit          = (col == cursor_x) && (row == cursor_y);

  // Position writes are clamped to the last valid cell.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cursor_x <= '0;
      cursor_y <= '0;
    end else if (new_cursor_wen) begin
      cursor_x <= (new_cursor_x > MAX_X) ? MAX_X : new_cursor_x;
      cursor_y <= (new_cursor_y > MAX_Y) ? MAX_Y : new_cursor_y;
    end
  end

  // vblank_q resets high so releasing reset during vblank is not a frame tick.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vblank_q <= 1'b1;
      mode_q   <= MODE_OFF;
    end else begin
      vblank_q <= vblank;
      mode_q   <= cursor_mode;
    end
  end

  // Cursor moves and mode changes restart the blink in its visible phase.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (new_cursor_wen || mode_changed) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_tick) begin
      if (blink_inc >= BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_inc;
      end
    end
  end

  // NOTE: defaulting every combinational output first keeps this block free
  // of inferred latches whatever the case coverage.
  always_comb begin
    cursor_pixel = 1'b0;
    unique case (mode_e'(cursor_mode))
      MODE_OFF:       cursor_pixel = 1'b0;
      MODE_STEADY:    cursor_pixel = hit;
      MODE_BLINK:     cursor_pixel = hit & blink_on;
      MODE_UNDERLINE: cursor_pixel = hit & blink_on & (scanline == UL_ROW);
      default:        cursor_pixel = 1'b0;
    endcase
  end

  assign video_d = (hblank || vblank) ? ~VIDEO_ON
                                      : (VIDEO_ON ^ ~(char_pixel ^ cursor_pixel));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) video <= ~VIDEO_ON;
    else      video <= video_d;
  end

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay: stimulus pushes expectations into a
// scoreboard that a separate monitor drains on the falling clock edge.
module tb_cursor_overlay;

  logic       clk;
  logic       clr;
  logic       hblank;
  logic       vblank;
  logic [4:0] row;
  logic [6:0] col;
  logic [3:0] scanline;
  logic       char_pixel;
  logic [6:0] new_cursor_x;
  logic [4:0] new_cursor_y;
  logic       new_cursor_wen;
  logic [1:0] cursor_mode;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       blink_on;
  logic       video;

  cursor_overlay #(.BLINK_FRAMES(2)) dut (
    .clk            (clk),
    .clr            (clr),
    .hblank         (hblank),
    .vblank         (vblank),
    .row            (row),
    .col            (col),
    .scanline       (scanline),
    .char_pixel     (char_pixel),
    .new_cursor_x   (new_cursor_x),
    .new_cursor_y   (new_cursor_y),
    .new_cursor_wen (new_cursor_wen),
    .cursor_mode    (cursor_mode),
    .cursor_x       (cursor_x),
    .cursor_y       (cursor_y),
    .blink_on       (blink_on),
    .video          (video)
  );

  typedef enum {SIG_VIDEO, SIG_X, SIG_Y, SIG_BLINK} sig_e;
  typedef struct {
    sig_e  sig;
    int    exp;
    int    due;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(sig_e s);
    case (s)
      SIG_VIDEO: return int'(video);
      SIG_X:     return int'(cursor_x);
      SIG_Y:     return int'(cursor_y);
      default:   return int'(blink_on);
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every expectation whose due cycle has arrived.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          check(sb[i].name, actual(sb[i].sig), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  // lat=0: state as of the last edge; lat=1: result of the inputs now driven.
  task automatic expect_sig(sig_e s, int exp, int lat, string name);
    sb.push_back('{s, exp, cyc + lat, name});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_cursor(int x, int y, int ex, int ey);
    new_cursor_x   = 7'(x);
    new_cursor_y   = 5'(y);
    new_cursor_wen = 1'b1;
    expect_sig(SIG_X, ex, 1, "cursor_x");
    expect_sig(SIG_Y, ey, 1, "cursor_y");
    step();
    new_cursor_wen = 1'b0;
  endtask

  task automatic pixel(int r, int c, int sl, int cp, int hb, int vb, int exp);
    row        = 5'(r);
    col        = 7'(c);
    scanline   = 4'(sl);
    char_pixel = 1'(cp);
    hblank     = 1'(hb);
    vblank     = 1'(vb);
    expect_sig(SIG_VIDEO, exp, 1, "video");
    step();
    hblank = 1'b0;
    vblank = 1'b0;
  endtask

  task automatic vpulse(int exp_blink);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
    expect_sig(SIG_BLINK, exp_blink, 0, "blink_on");
  endtask

  initial begin
    clr = 1'b0; hblank = 1'b0; vblank = 1'b0;
    row = '0; col = '0; scanline = '0; char_pixel = 1'b0;
    new_cursor_x = '0; new_cursor_y = '0; new_cursor_wen = 1'b0;
    cursor_mode = 2'b00;
    repeat (2) step();

    // Reset state
    expect_sig(SIG_X, 0, 0, "rst_cursor_x");
    expect_sig(SIG_Y, 0, 0, "rst_cursor_y");
    expect_sig(SIG_BLINK, 1, 0, "rst_blink_on");
    expect_sig(SIG_VIDEO, 0, 0, "rst_video");
    step();
    clr = 1'b1;
    step();

    // Position clamping
    write_cursor(100, 30, 79, 23);
    write_cursor(5, 3, 5, 3);
    write_cursor(79, 23, 79, 23);
    write_cursor(80, 24, 79, 23);
    write_cursor(3, 2, 3, 2);

    // Underline mode at cursor (3,2)
    cursor_mode = 2'b11;
    step();
    expect_sig(SIG_BLINK, 1, 0, "mode11_blink_on");
    pixel(2, 3, 15, 0, 0, 0, 1);
    pixel(2, 3, 14, 0, 0, 0, 0);
    pixel(2, 4, 15, 0, 0, 0, 0);
    pixel(2, 3, 15, 1, 0, 0, 0);
    pixel(1, 3, 15, 0, 0, 0, 0);

    // Steady block, blanking, cursor off
    cursor_mode = 2'b01;
    step();
    pixel(2, 3, 0, 0, 1, 0, 0);
    pixel(2, 3, 0, 0, 0, 0, 1);
    pixel(2, 3, 0, 1, 0, 0, 0);
    cursor_mode = 2'b00;
    step();
    pixel(2, 3, 0, 1, 0, 0, 1);
    pixel(2, 3, 0, 0, 0, 0, 0);
    pixel(7, 7, 0, 1, 0, 1, 0);

    // Blinking block, 2 frames per half-period
    cursor_mode = 2'b10;
    step();
    expect_sig(SIG_BLINK, 1, 0, "blink_after_mode");
    vpulse(1);
    vpulse(0);
    pixel(2, 3, 0, 0, 0, 0, 0);
    vpulse(0);
    vpulse(1);
    pixel(2, 3, 0, 0, 0, 0, 1);

    // A long vblank is a single frame tick
    vblank = 1'b1;
    repeat (5) step();
    vblank = 1'b0;
    step();
    expect_sig(SIG_BLINK, 1, 0, "long_vblank_one_tick");
    vpulse(0);

    // Cursor write coincident with a frame tick while hidden
    vpulse(0);
    new_cursor_x   = 7'd10;
    new_cursor_y   = 5'd5;
    new_cursor_wen = 1'b1;
    vblank         = 1'b1;
    expect_sig(SIG_X, 10, 1, "wen_tick_cursor_x");
    expect_sig(SIG_BLINK, 1, 1, "wen_tick_blink_on");
    step();
    new_cursor_wen = 1'b0;
    vblank         = 1'b0;
    step();
    vpulse(1);
    vpulse(0);

    cursor_mode = 2'b11;
    expect_sig(SIG_BLINK, 1, 1, "mode_change_blink_on");
    step();

    // Asynchronous reset during vblank
    cursor_mode = 2'b00;
    step();
    vpulse(1);
    vpulse(0);
    vblank = 1'b1;
    repeat (2) step();
    clr = 1'b0;
    expect_sig(SIG_X, 0, 0, "async_rst_cursor_x");
    expect_sig(SIG_Y, 0, 0, "async_rst_cursor_y");
    expect_sig(SIG_BLINK, 1, 0, "async_rst_blink_on");
    expect_sig(SIG_VIDEO, 0, 0, "async_rst_video");
    step();
    clr = 1'b1;
    repeat (3) step();
    expect_sig(SIG_BLINK, 1, 0, "no_tick_at_release");
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
    expect_sig(SIG_BLINK, 1, 0, "first_tick_after_rst");
    vpulse(0);

    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
